// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer. Fetches from program memory, decodes a 5-bit
// opcode and drives registered datapath strobes for one EXECUTE cycle per instruction.
module control_unit #(
  parameter int OPERAND_WIDTH = 11,
  parameter int DATA_WIDTH    = 16
) (
  input  logic                     clock_in,
  input  logic                     reset_in,
  input  logic [DATA_WIDTH-1:0]    instruction_in,
  input  logic                     flag_Z_in,
  input  logic                     flag_N_in,
  output logic [OPERAND_WIDTH-1:0] program_address_out,
  output logic [OPERAND_WIDTH-1:0] operand_out,
  output logic                     alu_op_out,
  output logic [1:0]               sel_A_out,
  output logic                     sel_B_out,
  output logic                     acc_wr_out,
  output logic                     acc_reset_out,
  output logic                     status_wr_out,
  output logic                     status_reset_out,
  output logic                     data_memory_wr_out,
  output logic                     halted_out
);

  localparam int OPCODE_W = DATA_WIDTH - OPERAND_WIDTH;

  localparam logic [OPCODE_W-1:0] OP_HLT  = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_STO  = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_LDI  = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_SUBI = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] OP_BGT  = OPCODE_W'(10);
  localparam logic [OPCODE_W-1:0] OP_BLT  = OPCODE_W'(11);
  localparam logic [OPCODE_W-1:0] OP_JMP  = OPCODE_W'(12);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_WAIT,
    S_EXECUTE,
    S_HALT
  } state_t;

  typedef struct packed {
    logic       alu_op;
    logic [1:0] sel_a;
    logic       sel_b;
    logic       acc_wr;
    logic       status_wr;
    logic       dmem_wr;
  } ctrl_t;

  state_t                   state;
  logic [OPERAND_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0]    ir;
  ctrl_t                    ctrl_q;
  logic                     halted_q;

  logic [OPCODE_W-1:0] opcode_in;
  logic [OPCODE_W-1:0] ir_op;

  assign opcode_in = instruction_in[DATA_WIDTH-1:OPERAND_WIDTH];
  assign ir_op     = ir[DATA_WIDTH-1:OPERAND_WIDTH];

  function automatic ctrl_t decode_ctrl(input logic [OPCODE_W-1:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_STO:  c.dmem_wr = 1'b1;
      OP_LD:   begin c.acc_wr = 1'b1; c.status_wr = 1'b1; c.sel_a = 2'b01; end
      OP_LDI:  begin c.acc_wr = 1'b1; c.status_wr = 1'b1; c.sel_a = 2'b10; end
      OP_ADD:  begin c.acc_wr = 1'b1; c.status_wr = 1'b1; end
      OP_ADDI: begin c.acc_wr = 1'b1; c.status_wr = 1'b1; c.sel_b = 1'b1; end
      OP_SUB:  begin c.acc_wr = 1'b1; c.status_wr = 1'b1; c.alu_op = 1'b1; end
      OP_SUBI: begin c.acc_wr = 1'b1; c.status_wr = 1'b1; c.alu_op = 1'b1; c.sel_b = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Only these opcodes read data memory, which needs an extra cycle of address setup.
  function automatic logic needs_mem(input logic [OPCODE_W-1:0] op);
    return (op == OP_LD) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic branch_taken(input logic [OPCODE_W-1:0] op,
                                        input logic z, input logic n);
    logic t;
    case (op)
      OP_BEQ:  t = z;
      OP_BNE:  t = ~z;
      OP_BGT:  t = ~z & ~n;
      OP_BLT:  t = n;
      OP_JMP:  t = 1'b1;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state    <= S_FETCH;
      pc       <= '0;
      ir       <= '0;
      ctrl_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      case (state)
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          ir <= instruction_in;
          if (opcode_in == OP_HLT) begin
            state    <= S_HALT;
            halted_q <= 1'b1;
          end else if (needs_mem(opcode_in)) begin
            state <= S_MEM_WAIT;
          end else begin
            state  <= S_EXECUTE;
            ctrl_q <= decode_ctrl(opcode_in);
          end
        end
        S_MEM_WAIT: begin
          state  <= S_EXECUTE;
          ctrl_q <= decode_ctrl(ir_op);
        end
        S_EXECUTE: begin
          state  <= S_FETCH;
          ctrl_q <= '0;
          if (branch_taken(ir_op, flag_Z_in, flag_N_in))
            pc <= ir[OPERAND_WIDTH-1:0];
          else
            pc <= pc + OPERAND_WIDTH'(1);
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Reset masks every registered strobe immediately so an aborted EXECUTE writes nothing.
  assign program_address_out = pc;
  assign operand_out         = ir[OPERAND_WIDTH-1:0];
  assign alu_op_out          = ctrl_q.alu_op & ~reset_in;
  assign sel_A_out           = ctrl_q.sel_a & {2{~reset_in}};
  assign sel_B_out           = ctrl_q.sel_b & ~reset_in;
  assign acc_wr_out          = ctrl_q.acc_wr & ~reset_in;
  assign status_wr_out       = ctrl_q.status_wr & ~reset_in;
  assign data_memory_wr_out  = ctrl_q.dmem_wr & ~reset_in;
  assign halted_out          = halted_q & ~reset_in;
  assign acc_reset_out       = reset_in;
  assign status_reset_out    = reset_in;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: program memory model plus an instruction-level reference
// that predicts address, operand and strobes for every cycle.
module tb_control_unit;

  logic        clock_in = 1'b0;
  logic        reset_in = 1'b0;
  logic [15:0] instruction_in = '0;
  logic        flag_Z_in = 1'b0;
  logic        flag_N_in = 1'b0;
  logic [10:0] program_address_out;
  logic [10:0] operand_out;
  logic        alu_op_out;
  logic [1:0]  sel_A_out;
  logic        sel_B_out;
  logic        acc_wr_out, acc_reset_out, status_wr_out, status_reset_out;
  logic        data_memory_wr_out, halted_out;

  control_unit #(.OPERAND_WIDTH(11), .DATA_WIDTH(16)) dut (
    .clock_in(clock_in), .reset_in(reset_in), .instruction_in(instruction_in),
    .flag_Z_in(flag_Z_in), .flag_N_in(flag_N_in),
    .program_address_out(program_address_out), .operand_out(operand_out),
    .alu_op_out(alu_op_out), .sel_A_out(sel_A_out), .sel_B_out(sel_B_out),
    .acc_wr_out(acc_wr_out), .acc_reset_out(acc_reset_out),
    .status_wr_out(status_wr_out), .status_reset_out(status_reset_out),
    .data_memory_wr_out(data_memory_wr_out), .halted_out(halted_out)
  );

  always #5 clock_in = ~clock_in;

  logic [15:0] pmem [0:2047];
  always @(posedge clock_in) instruction_in <= pmem[program_address_out];

  // {alu_op, sel_A, sel_B, acc_wr, acc_reset, status_wr, status_reset, dmem_wr, halted}
  logic [9:0] ctrl_vec;
  assign ctrl_vec = {alu_op_out, sel_A_out, sel_B_out, acc_wr_out, acc_reset_out,
                     status_wr_out, status_reset_out, data_memory_wr_out, halted_out};

  localparam logic [9:0] V_IDLE   = 10'h000;
  localparam logic [9:0] V_RESET  = 10'h014;
  localparam logic [9:0] V_HALTED = 10'h001;
  localparam logic [15:0] W_NOP   = 16'h6800;

  int vectors = 0;
  int miscompares = 0;

  logic [10:0] m_pc;
  logic [10:0] m_opd;
  bit          flag_rand = 1'b1;
  logic        fz = 1'b0, fn = 1'b0;

  function automatic logic [15:0] enc(input int op, input int opd);
    logic [4:0]  o;
    logic [10:0] d;
    o = 5'(op);
    d = 11'(opd);
    return {o, d};
  endfunction

  function automatic logic [9:0] exp_exec(input logic [4:0] op);
    logic alu, selb, aw, sw, dw;
    logic [1:0] sa;
    {alu, selb, aw, sw, dw} = '0;
    sa = 2'b00;
    case (op)
      5'd1: dw = 1'b1;
      5'd2: begin aw = 1'b1; sw = 1'b1; sa = 2'b01; end
      5'd3: begin aw = 1'b1; sw = 1'b1; sa = 2'b10; end
      5'd4: begin aw = 1'b1; sw = 1'b1; end
      5'd5: begin aw = 1'b1; sw = 1'b1; selb = 1'b1; end
      5'd6: begin aw = 1'b1; sw = 1'b1; alu = 1'b1; end
      5'd7: begin aw = 1'b1; sw = 1'b1; alu = 1'b1; selb = 1'b1; end
      default: ;
    endcase
    return {alu, sa, selb, aw, 1'b0, sw, 1'b0, dw, 1'b0};
  endfunction

  function automatic bit model_taken(input logic [4:0] op, input logic z, input logic n);
    case (op)
      5'd8:  return z == 1'b1;
      5'd9:  return z == 1'b0;
      5'd10: return (z == 1'b0) && (n == 1'b0);
      5'd11: return n == 1'b1;
      5'd12: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) pmem[i] = W_NOP;
  endtask

  task automatic check_cycle(input string name, input logic [10:0] ea,
                             input logic [10:0] eo, input logic [9:0] ec);
    @(negedge clock_in);
    if (flag_rand) begin
      flag_Z_in = 1'($urandom);
      flag_N_in = 1'($urandom);
    end else begin
      flag_Z_in = fz;
      flag_N_in = fn;
    end
    vectors++;
    if (program_address_out !== ea || operand_out !== eo || ctrl_vec !== ec) begin
      miscompares++;
      $display("FAIL %s @pc=%h: addr=%h want %h, operand=%h want %h, ctrl=%b want %b",
               name, ea, program_address_out, ea, operand_out, eo, ctrl_vec, ec);
    end
  endtask

  task automatic do_reset();
    @(negedge clock_in);
    reset_in = 1'b1;
    #1;
    vectors++;
    if (ctrl_vec !== V_RESET) begin
      miscompares++;
      $display("FAIL reset_outputs: ctrl=%b want %b", ctrl_vec, V_RESET);
    end
    @(posedge clock_in);
    #1;
    reset_in = 1'b0;
    m_pc  = '0;
    m_opd = '0;
  endtask

  // Executes one instruction of the model, checking every cycle the DUT spends on it.
  task automatic run_instr(output bit hit_halt);
    logic [15:0] w;
    logic [4:0]  op;
    logic [10:0] opd;
    w   = pmem[m_pc];
    op  = w[15:11];
    opd = w[10:0];
    hit_halt = 1'b0;
    check_cycle("fetch", m_pc, m_opd, V_IDLE);
    check_cycle("decode", m_pc, m_opd, V_IDLE);
    m_opd = opd;
    if (op == 5'd0) begin
      for (int i = 0; i < 12; i++) check_cycle("halt", m_pc, opd, V_HALTED);
      hit_halt = 1'b1;
      return;
    end
    if (op == 5'd2 || op == 5'd4 || op == 5'd6)
      check_cycle("mem_wait", m_pc, opd, V_IDLE);
    check_cycle("execute", m_pc, opd, exp_exec(op));
    m_pc = model_taken(op, flag_Z_in, flag_N_in) ? opd : m_pc + 11'd1;
  endtask

  task automatic test_reset();
    bit h;
    clear_mem();
    do_reset();
    check_cycle("post_reset_fetch", 11'h000, 11'h000, V_IDLE);
    m_pc = 11'h000;
    m_opd = 11'h000;
    do_reset();
    run_instr(h);
  endtask

  task automatic test_ldi();
    bit h;
    clear_mem();
    pmem[0] = enc(3, 5);
    do_reset();
    run_instr(h);
    if (m_pc !== 11'h001) begin
      miscompares++;
      $display("FAIL ldi_next_pc: model pc=%h want 001", m_pc);
    end
    vectors++;
    run_instr(h);
  endtask

  task automatic test_alu_ops();
    bit h;
    clear_mem();
    pmem[0] = enc(4, 3);
    pmem[1] = enc(6, 9);
    pmem[2] = enc(5, 11'h7F0);
    pmem[3] = enc(7, 1);
    pmem[4] = enc(2, 11'h2AA);
    do_reset();
    for (int i = 0; i < 6; i++) run_instr(h);
  endtask

  task automatic test_branch();
    bit h;
    clear_mem();
    pmem[0]     = enc(8, 11'h040);
    pmem[11'h040] = enc(8, 11'h080);
    flag_rand = 1'b0;
    fn = 1'b0;
    fz = 1'b1;
    do_reset();
    run_instr(h);
    fz = 1'b0;
    run_instr(h);
    run_instr(h);
    if (m_pc !== 11'h042) begin
      miscompares++;
      $display("FAIL branch_path: model pc=%h want 042", m_pc);
    end
    vectors++;
    run_instr(h);
    flag_rand = 1'b1;
  endtask

  task automatic test_sto();
    bit h;
    clear_mem();
    pmem[0] = enc(1, 7);
    do_reset();
    run_instr(h);
    run_instr(h);
  endtask

  task automatic test_wrap();
    bit h;
    clear_mem();
    pmem[0]       = enc(12, 11'h7FF);
    pmem[11'h7FF] = W_NOP;
    do_reset();
    for (int i = 0; i < 3; i++) run_instr(h);
  endtask

  task automatic test_halt();
    bit h;
    clear_mem();
    pmem[0] = enc(3, 1);
    pmem[1] = enc(0, 11'h123);
    do_reset();
    run_instr(h);
    run_instr(h);
    vectors++;
    if (h !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_reached: got %0d want 1", h);
    end
    do_reset();
    run_instr(h);
  endtask

  task automatic test_reset_mid_execute();
    bit h;
    clear_mem();
    pmem[0]       = enc(12, 11'h010);
    pmem[11'h010] = enc(5, 7);
    do_reset();
    run_instr(h);
    check_cycle("abort_fetch", 11'h010, 11'h010, V_IDLE);
    check_cycle("abort_decode", 11'h010, 11'h010, V_IDLE);
    check_cycle("abort_execute", 11'h010, 11'h007, exp_exec(5'd5));
    reset_in = 1'b1;
    #1;
    vectors++;
    if (ctrl_vec !== V_RESET) begin
      miscompares++;
      $display("FAIL abort_same_cycle: ctrl=%b want %b", ctrl_vec, V_RESET);
    end
    @(negedge clock_in);
    vectors++;
    if (ctrl_vec !== V_RESET || program_address_out !== 11'h000) begin
      miscompares++;
      $display("FAIL abort_next_cycle: ctrl=%b want %b addr=%h want 000",
               ctrl_vec, V_RESET, program_address_out);
    end
    @(posedge clock_in);
    #1;
    reset_in = 1'b0;
    m_pc = 11'h000;
    m_opd = 11'h000;
    run_instr(h);
  endtask

  task automatic test_random();
    bit h;
    int op;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 2048; i++) begin
        op = $urandom_range(1, 14);
        if (op == 14) op = $urandom_range(14, 31);
        pmem[i] = enc(op, $urandom_range(0, 2047));
      end
      flag_rand = 1'b1;
      do_reset();
      for (int k = 0; k < 150; k++) begin
        run_instr(h);
        if (h) break;
      end
    end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_alu_ops();
    test_branch();
    test_sto();
    test_wrap();
    test_halt();
    test_reset_mid_execute();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t want < 2000000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
